frac_baud_gen: RTL and testbench
================================

Name: frac_baud_gen

Overview:
Programmable fractional baud-rate tick generator for the UART datapath on the 100 MHz system clock. It produces an oversampling tick (s_tick) whose average period is div_int + div_frac/2^DIV_FRAC_W clock cycles. It also produces a bit tick (bit_tick) every OVS oversampling ticks. The divisor is runtime-loadable without glitches, and the phase can be re-aligned to a receiver start-bit edge.

Parameters:
DIV_INT_W, 12, width of integer divisor part
DIV_FRAC_W, 4, width of fractional divisor part (1/16 cycle resolution)
OVS, 16, oversampling ticks per bit tick (>=2)
OVS_W, 4, width of oversample counter (2^OVS_W >= OVS)
DEF_INT, 651, integer divisor after reset
DEF_FRAC, 1, fractional divisor after reset (651.0625 -> ~9600 baud x16)

Ports:
clk_100MHz  in   1             system clock; all logic on rising edge
rst         in   1             reset, synchronous, active-high
en          in   1             count enable; low freezes all counters
div_int     in   DIV_INT_W     integer divisor, sampled on div_load
div_frac    in   DIV_FRAC_W    fractional divisor, sampled on div_load
div_load    in   1             one-cycle strobe; captures div_int/div_frac into shadow
ovs_sync    in   1             phase re-align strobe (start-bit detect)
s_tick      out  1             registered 1-cycle oversampling tick
bit_tick    out  1             registered 1-cycle tick on every OVS-th s_tick
cfg_err     out  1             sticky flag: last loaded div_int < 2

Behaviour:
- Single clock domain. Reset is synchronous, active-high; clock port clk_100MHz, reset port rst.
- Reset values:
  - s_tick=0, bit_tick=0, cfg_err=0.
  - Active divisor = shadow = {DEF_INT, DEF_FRAC}.
  - cnt=0, frac_acc=0, carry=0, ovs_cnt=0, pending=0.
- Period rule:
  - Current period P = act_int + carry.
  - cnt runs 0..P-1 on enabled cycles.
  - Terminal count (TC) = en && cnt==P-1.
- At TC:
  - cnt <= 0.
  - {carry, frac_acc} <= frac_acc + act_frac. The sum is DIV_FRAC_W+1 bits; the carry lengthens the next period by exactly 1.
  - s_tick <= 1 for exactly one cycle.
- The first s_tick after rst deassertion (en held high) is registered on the P-th enabled edge, giving a 1-cycle output latency. s_tick pulses are exactly P cycles apart.
- Oversample counter:
  - On each TC, ovs_cnt increments.
  - When ovs_cnt==OVS-1 at TC, ovs_cnt <= 0 and bit_tick <= 1 in the same cycle as s_tick.
  - bit_tick never asserts without s_tick.
- en low: cnt, frac_acc, carry and ovs_cnt hold; s_tick=0 and bit_tick=0 on the next cycle. Counting resumes where it left off.
- div_load:
  - Shadow <= {div_int, div_frac}. If div_int<2, shadow int is clamped to 2 and cfg_err <= 1. If div_int>=2, cfg_err <= 0.
  - If en=0: the shadow becomes active on the next edge; cnt, frac_acc, carry and ovs_cnt are cleared.
  - If en=1: pending <= 1. At the next TC whose cycle is strictly after the load cycle, the new divisor becomes active and frac_acc, carry and pending are cleared (the s_tick for that TC is still emitted). ovs_cnt is not cleared.
  - A load in the same cycle as a TC is not applied at that TC; it is applied at the following TC.
  - Back-to-back loads: the last one wins; only one apply occurs.
- ovs_sync:
  - Clears cnt, frac_acc, carry and ovs_cnt.
  - Suppresses s_tick/bit_tick for that cycle, even if TC was due.
  - A pending divisor is applied immediately.
- Priority: rst > ovs_sync > div_load apply > normal count.
- Width rules: cnt is DIV_INT_W+1 bits so act_int+carry never overflows, including act_int = 2^DIV_INT_W - 1. Maximum period = 2^DIV_INT_W cycles; minimum period = 2.

Test Plan:
1. Reset then en=1, default divisor 651/1: first s_tick 651 cycles after the first enabled edge; the 16th s_tick arrives 15 periods later; total cycles over 16 periods = 10417 (16×651.0625 = 10417); bit_tick coincides with the 16th s_tick; cfg_err=0.
2. Load div_int=10, div_frac=4 with en=0, then enable: tick spacings are 10,10,10,11 repeating; 16 ticks span exactly 164 cycles.
3. Load div_int=20, div_frac=0 mid-period at cnt=3 of a 10-cycle period (en=1): current period completes at 10 cycles, then spacing is 20. A second load of 5 issued in the same cycle as that TC takes effect one period later.
4. en deasserted for 7 cycles at cnt=4 (div_int=10, div_frac=0): no ticks during the gap; the next tick arrives 6 enabled cycles after re-enable (10 enabled cycles per period in total).
5. ovs_sync pulsed in the same cycle as a due TC, with ovs_cnt=9: no s_tick that cycle; ovs_cnt=0; the next s_tick arrives P cycles later; bit_tick arrives after 16 further s_ticks.
6. Load div_int=1 then div_int=0: cfg_err=1 and s_tick every 2 cycles; load div_int=8: cfg_err=0 and spacing 8. Assert rst mid-period: all outputs 0 next cycle and the divisor returns to 651/1.

Source files
------------

// File: rtl/frac_baud_gen.sv
// -----------------------------------------------------------------------------
// frac_baud_gen
//
// Fractional baud-rate tick generator for the UART datapath.
//
// The s_tick output pulses with an average period of
//   div_int + div_frac / 2^DIV_FRAC_W   clock cycles.
//
// How the fractional period is built:
//   - A first-order accumulator (frac_acc) adds div_frac at every terminal count.
//   - Its carry-out stretches the following period by exactly one cycle.
//
// Every OVS-th s_tick is also flagged on bit_tick.
//
// Ports:
//   clk_100MHz  in   system clock, all state on the rising edge
//   rst         in   synchronous active-high reset
//   en          in   count enable; low freezes the counters and silences ticks
//   div_int     in   integer divisor part, captured on div_load
//   div_frac    in   fractional divisor part, captured on div_load
//   div_load    in   one-cycle strobe that captures div_int/div_frac into shadow
//   ovs_sync    in   phase re-align strobe (receiver start-bit edge)
//   s_tick      out  registered one-cycle oversampling tick
//   bit_tick    out  registered one-cycle tick coincident with every OVS-th s_tick
//   cfg_err     out  sticky flag: last loaded div_int was below 2 (clamped to 2)
// -----------------------------------------------------------------------------
module frac_baud_gen #(
    parameter int DIV_INT_W  = 12,
    parameter int DIV_FRAC_W = 4,
    parameter int OVS        = 16,
    parameter int OVS_W      = 4,
    parameter int DEF_INT    = 651,
    parameter int DEF_FRAC   = 1
) (
    input  logic                  clk_100MHz,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIV_INT_W-1:0]  div_int,
    input  logic [DIV_FRAC_W-1:0] div_frac,
    input  logic                  div_load,
    input  logic                  ovs_sync,
    output logic                  s_tick,
    output logic                  bit_tick,
    output logic                  cfg_err
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [DIV_INT_W-1:0]  DEF_INT_L  = DIV_INT_W'(DEF_INT);
    localparam logic [DIV_FRAC_W-1:0] DEF_FRAC_L = DIV_FRAC_W'(DEF_FRAC);
    localparam logic [DIV_INT_W-1:0]  MIN_INT    = DIV_INT_W'(2);
    localparam logic [DIV_INT_W:0]    CNT_ONE    = (DIV_INT_W+1)'(1);
    localparam logic [OVS_W-1:0]      OVS_ONE    = OVS_W'(1);
    localparam logic [OVS_W-1:0]      OVS_LAST   = OVS_W'(OVS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Active divisor (drives the counter) and shadow divisor (last load).
    logic [DIV_INT_W-1:0]  act_int_q,  act_int_d;
    logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_INT_W-1:0]  shd_int_q,  shd_int_d;
    logic [DIV_FRAC_W-1:0] shd_frac_q, shd_frac_d;

    // cnt is one bit wider than act_int so that act_int + carry always fits,
    // including act_int = 2^DIV_INT_W - 1 with carry set.
    logic [DIV_INT_W:0]    cnt_q,      cnt_d;
    logic [DIV_FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic                  carry_q,    carry_d;
    logic [OVS_W-1:0]      ovs_cnt_q,  ovs_cnt_d;
    logic                  pending_q,  pending_d;

    logic                  s_tick_q,   s_tick_d;
    logic                  bit_tick_q, bit_tick_d;
    logic                  cfg_err_q,  cfg_err_d;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic [DIV_INT_W:0]    period;
    logic [DIV_INT_W:0]    period_m1;
    logic                  tc;
    logic [DIV_FRAC_W:0]   frac_sum;
    logic                  ld_low;
    logic [DIV_INT_W-1:0]  ld_int;

    // Current period, stretched by one cycle when the last accumulation
    // overflowed.
    assign period    = {1'b0, act_int_q} + {{DIV_INT_W{1'b0}}, carry_q};
    assign period_m1 = period - CNT_ONE;
    assign tc        = en && (cnt_q == period_m1);

    // Fraction accumulation; the MSB of the sum is the next carry.
    assign frac_sum  = {1'b0, frac_acc_q} + {1'b0, act_frac_q};

    // Divisors below 2 cannot produce a one-cycle-low tick train.
    // Clamp them to 2 and flag the configuration error.
    assign ld_low    = (div_int < MIN_INT);
    assign ld_int    = ld_low ? MIN_INT : div_int;

    // -------------------------------------------------------------------------
    // Next-state logic
    // Precedence: ovs_sync > divisor apply > normal count.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        cnt_d      = cnt_q;
        frac_acc_d = frac_acc_q;
        carry_d    = carry_q;
        ovs_cnt_d  = ovs_cnt_q;
        pending_d  = pending_q;
        s_tick_d   = 1'b0;
        bit_tick_d = 1'b0;
        cfg_err_d  = cfg_err_q;

        // Shadow capture is independent of counting.
        if (div_load) begin
            shd_int_d  = ld_int;
            shd_frac_d = div_frac;
            cfg_err_d  = ld_low;
        end

        if (ovs_sync) begin
            // Re-align phase to the start-bit edge.
            // Any tick due this cycle is dropped.
            cnt_d      = '0;
            frac_acc_d = '0;
            carry_d    = 1'b0;
            ovs_cnt_d  = '0;
            if (pending_q) begin
                act_int_d  = shd_int_q;
                act_frac_d = shd_frac_q;
                pending_d  = 1'b0;
            end
        end else if (div_load && !en) begin
            // Counter is idle, so the new divisor can take over at once
            // from a clean phase.
            act_int_d  = ld_int;
            act_frac_d = div_frac;
            cnt_d      = '0;
            frac_acc_d = '0;
            carry_d    = 1'b0;
            ovs_cnt_d  = '0;
            pending_d  = 1'b0;
        end else if (tc) begin
            cnt_d                = '0;
            {carry_d, frac_acc_d} = frac_sum;
            s_tick_d             = 1'b1;
            if (ovs_cnt_q == OVS_LAST) begin
                ovs_cnt_d  = '0;
                bit_tick_d = 1'b1;
            end else begin
                ovs_cnt_d  = ovs_cnt_q + OVS_ONE;
            end
            // A load seen before this TC swaps in at the period boundary.
            // The new divisor starts with a fresh fraction phase.
            if (pending_q) begin
                act_int_d  = shd_int_q;
                act_frac_d = shd_frac_q;
                frac_acc_d = '0;
                carry_d    = 1'b0;
                pending_d  = 1'b0;
            end
        end else if (en) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // A running load arms the swap for the next TC.
        // Coming last, this also covers a load landing on a TC: that TC
        // consumed the older pending value, and this one waits for the
        // following TC.
        if (div_load && en) begin
            pending_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            act_int_q  <= DEF_INT_L;
            act_frac_q <= DEF_FRAC_L;
            shd_int_q  <= DEF_INT_L;
            shd_frac_q <= DEF_FRAC_L;
            cnt_q      <= '0;
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
            ovs_cnt_q  <= '0;
            pending_q  <= 1'b0;
            s_tick_q   <= 1'b0;
            bit_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            cnt_q      <= cnt_d;
            frac_acc_q <= frac_acc_d;
            carry_q    <= carry_d;
            ovs_cnt_q  <= ovs_cnt_d;
            pending_q  <= pending_d;
            s_tick_q   <= s_tick_d;
            bit_tick_q <= bit_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign s_tick   = s_tick_q;
    assign bit_tick = bit_tick_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_frac_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_frac_baud_gen
//
// Directed bench for frac_baud_gen with the default parameters.
//
// Timing convention:
//   - Inputs change and outputs are sampled 1 ns after each rising edge.
//   - cyc counts rising edges.
//   - A tick "at cycle N" is the s_tick seen just after edge N.
// -----------------------------------------------------------------------------
module tb_frac_baud_gen;

    logic        clk_100MHz = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        ovs_sync;
    logic        s_tick;
    logic        bit_tick;
    logic        cfg_err;

    int cyc        = 0;
    int pass_cnt   = 0;
    int total_cnt  = 0;
    int tick_cnt   = 0;
    int bit_cnt    = 0;
    int orphan_cnt = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    frac_baud_gen dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .en         (en),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_load   (div_load),
        .ovs_sync   (ovs_sync),
        .s_tick     (s_tick),
        .bit_tick   (bit_tick),
        .cfg_err    (cfg_err)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
        cyc++;
        if (s_tick) tick_cnt++;
        if (bit_tick) bit_cnt++;
        if (bit_tick && !s_tick) orphan_cnt++;
    endtask

    // Advance until s_tick is seen, bounded by limit edges.
    // Returns the cycle at which the tick is seen.
    task automatic wait_tick(input string tag, input int limit, output int t);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!s_tick && k < limit);
        check({tag, "_seen"}, longint'(s_tick), 1);
        t = cyc;
    endtask

    task automatic load(input int i, input int f);
        div_int  = 12'(i);
        div_frac = 4'(f);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tp, tn, b0, k0;

        rst      = 1'b1;
        en       = 1'b0;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;
        ovs_sync = 1'b0;
        repeat (3) step();
        check("rst_s_tick",   longint'(s_tick),   0);
        check("rst_bit_tick", longint'(bit_tick), 0);
        check("rst_cfg_err",  longint'(cfg_err),  0);

        // ---- 1: default divisor 651 + 1/16 ----
        rst = 1'b0;
        en  = 1'b1;
        t0  = cyc;
        wait_tick("t1_first", 700, t1);
        check("t1_first_latency", t1 - t0, 651);
        check("t1_first_bit", longint'(bit_tick), 0);
        step();
        check("t1_pulse_width", longint'(s_tick), 0);
        for (int i = 0; i < 15; i++) wait_tick("t1_run", 700, tn);
        check("t1_16th_span", tn - t1, 9765);
        check("t1_16th_bit", longint'(bit_tick), 1);
        check("t1_bit_count", bit_cnt, 1);
        wait_tick("t1_17th", 700, tn);
        check("t1_16_periods", tn - t1, 10417);
        check("t1_cfg_err", longint'(cfg_err), 0);

        // ---- 2: 10 + 4/16 loaded while idle ----
        en = 1'b0;
        load(10, 4);
        en = 1'b1;
        t0 = cyc;
        wait_tick("t2_first", 20, t1);
        check("t2_first_latency", t1 - t0, 10);
        b0 = bit_cnt;
        tp = t1;
        for (int i = 1; i <= 16; i++) begin
            wait_tick("t2_run", 20, tn);
            check($sformatf("t2_spacing_%0d", i), tn - tp, (i % 4 == 0) ? 11 : 10);
            tp = tn;
        end
        check("t2_16_periods", tn - t1, 164);
        check("t2_bit_count", bit_cnt - b0, 1);

        // ---- 3: running load at cnt=3, then load coinciding with TC ----
        en = 1'b0;
        load(10, 0);
        en = 1'b1;
        t0 = cyc;
        wait_tick("t3_first", 20, tp);
        check("t3_first_latency", tp - t0, 10);
        repeat (3) step();
        load(20, 0);
        wait_tick("t3_old_period", 30, tn);
        check("t3_old_period", tn - tp, 10);
        tp = tn;
        wait_tick("t3_new_period", 30, tn);
        check("t3_new_period", tn - tp, 20);
        tp = tn;
        repeat (19) step();
        load(5, 0);
        check("t3_tc_with_load", longint'(s_tick), 1);
        check("t3_tc_spacing", cyc - tp, 20);
        tp = cyc;
        wait_tick("t3_deferred", 30, tn);
        check("t3_deferred", tn - tp, 20);
        tp = tn;
        wait_tick("t3_applied", 30, tn);
        check("t3_applied", tn - tp, 5);

        // ---- 4: enable gap of 7 cycles at cnt=4 ----
        en = 1'b0;
        load(10, 0);
        en = 1'b1;
        wait_tick("t4_first", 20, tp);
        repeat (4) step();
        en = 1'b0;
        k0 = tick_cnt;
        repeat (7) step();
        check("t4_gap_ticks", tick_cnt - k0, 0);
        en = 1'b1;
        t0 = cyc;
        wait_tick("t4_resume", 20, tn);
        check("t4_resume", tn - t0, 6);

        // ---- 5: ovs_sync on a due TC with ovs_cnt=9 ----
        en = 1'b0;
        load(10, 0);
        en = 1'b1;
        for (int i = 0; i < 9; i++) wait_tick("t5_pre", 20, tp);
        repeat (9) step();
        ovs_sync = 1'b1;
        step();
        ovs_sync = 1'b0;
        check("t5_sync_suppress", longint'(s_tick), 0);
        t0 = cyc;
        b0 = bit_cnt;
        wait_tick("t5_after_sync", 20, tn);
        check("t5_after_sync", tn - t0, 10);
        for (int i = 0; i < 15; i++) wait_tick("t5_run", 20, tn);
        check("t5_16th_bit", longint'(bit_tick), 1);
        check("t5_bit_count", bit_cnt - b0, 1);
        tp = tn;

        // ---- 6: clamped divisors, recovery, reset ----
        load(1, 0);
        load(0, 0);
        check("t6_cfg_err_set", longint'(cfg_err), 1);
        wait_tick("t6_old_period", 20, tn);
        check("t6_old_period", tn - tp, 10);
        tp = tn;
        for (int i = 0; i < 3; i++) begin
            wait_tick("t6_clamped", 10, tn);
            check($sformatf("t6_clamped_%0d", i), tn - tp, 2);
            tp = tn;
        end
        load(8, 0);
        check("t6_cfg_err_clear", longint'(cfg_err), 0);
        wait_tick("t6_apply", 10, tn);
        check("t6_apply", tn - tp, 2);
        tp = tn;
        wait_tick("t6_eight", 20, tn);
        check("t6_eight", tn - tp, 8);
        load(1, 0);
        check("t6_cfg_err_again", longint'(cfg_err), 1);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("t6_rst_s_tick",   longint'(s_tick),   0);
        check("t6_rst_bit_tick", longint'(bit_tick), 0);
        check("t6_rst_cfg_err",  longint'(cfg_err),  0);
        rst = 1'b0;
        t0  = cyc;
        wait_tick("t6_default", 700, tn);
        check("t6_default_latency", tn - t0, 651);

        check("bit_without_s_tick", orphan_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
